// File: rtl/trace_pkg.sv
// Shared constants and state encoding for the CPU trace record streamer.
package trace_pkg;

    localparam int          DATA_W       = 32;
    localparam logic [15:0] SYNC_MARK    = 16'hC0DE;
    localparam int          RECORD_WORDS = 35;
    localparam int          HDR_WORDS    = 3;
    localparam int          IDX_W        = $clog2(RECORD_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        REGS = 2'd2
    } state_t;

endpackage

// File: rtl/trace_streamer.sv
// Streams one {header, pc, instr, regfile} record per traced commit on a
// valid/ready word interface, stalling the CPU while the record is in flight.
module trace_streamer #(
    parameter int          NUM_REGS  = 32,
    parameter logic [15:0] SYNC_MARK = trace_pkg::SYNC_MARK
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        trace_en,
    input  logic                        commit_valid,
    input  logic [31:0]                 commit_pc,
    input  logic [31:0]                 commit_inst,
    output logic                        cpu_stall,
    output logic [$clog2(NUM_REGS)-1:0] dbg_raddr,
    input  logic [31:0]                 dbg_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_data,
    output logic                        out_last,
    output logic                        busy
);
    import trace_pkg::*;

    localparam int              AW       = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(HDR_WORDS - 1);
    localparam logic [IDX_W-1:0] REC_LAST = IDX_W'(HDR_WORDS + NUM_REGS - 1);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   word_idx;   // index of the word currently on out_data
    logic [15:0]        seq;
    logic [DATA_W-1:0]  cap_pc;
    logic [DATA_W-1:0]  cap_inst;
    logic               capture;
    logic               xfer;

    // State register; reset aborts any record in flight.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; stall is asserted for every non-idle cycle.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        cpu_stall  = 1'b0;
        xfer       = out_valid && out_ready;
        case (state)
            IDLE: begin
                if (trace_en && commit_valid) begin
                    capture    = 1'b1;
                    state_next = HDR;
                end
            end
            HDR: begin
                cpu_stall = 1'b1;
                if (xfer && word_idx == HDR_LAST) state_next = REGS;
            end
            REGS: begin
                cpu_stall = 1'b1;
                if (xfer && word_idx == REC_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        busy = cpu_stall;
    end

    // Debug read address points at the register feeding the next word load;
    // it stays 0 through the header and wraps harmlessly on the final word.
    always_comb begin
        dbg_raddr = '0;
        if (word_idx >= HDR_LAST) dbg_raddr = AW'(word_idx - HDR_LAST);
    end

    // pc/instr snapshot taken on the capture edge; pure data, no reset needed.
    always_ff @(posedge clk_in) begin
        if (capture) begin
            cap_pc   <= commit_pc;
            cap_inst <= commit_inst;
        end
    end

    // Output word register, word counter and record sequence number.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            word_idx  <= '0;
            seq       <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= {SYNC_MARK, seq};
            out_last  <= 1'b0;
            word_idx  <= '0;
        end else if (state != IDLE && xfer) begin
            if (word_idx == REC_LAST) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_last  <= 1'b0;
                word_idx  <= '0;
                seq       <= seq + 16'd1;
            end else begin
                word_idx <= word_idx + IDX_W'(1);
                out_last <= (word_idx == REC_LAST - IDX_W'(1));
                if (word_idx == '0)            out_data <= cap_pc;
                else if (word_idx == IDX_W'(1)) out_data <= cap_inst;
                else                            out_data <= dbg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_trace_streamer.sv
// Self-checking bench for trace_streamer: a regfile model answers debug reads,
// and each captured record is compared with one rebuilt from the record rules.
module tb_trace_streamer;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [31:0] commit_inst = '0;
    logic        cpu_stall;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    logic [31:0] regs [32];
    logic [31:0] got_w [64];
    logic        got_l [64];
    int          n_got;
    int          stall_cyc;
    logic [15:0] exp_seq;
    int          checks = 0;
    int          errors = 0;

    trace_streamer dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .trace_en    (trace_en),
        .commit_valid(commit_valid),
        .commit_pc   (commit_pc),
        .commit_inst (commit_inst),
        .cpu_stall   (cpu_stall),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy)
    );

    assign dbg_rdata = regs[dbg_raddr];

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Expected record word i from the record layout.
    function automatic logic [31:0] exp_word(input int i, input logic [15:0] s,
                                             input logic [31:0] pc, input logic [31:0] inst);
        if (i == 0)      return {16'hC0DE, s};
        else if (i == 1) return pc;
        else if (i == 2) return inst;
        else             return regs[i-3];
    endfunction

    task automatic commit(input logic [31:0] pc, input logic [31:0] inst);
        commit_pc    = pc;
        commit_inst  = inst;
        commit_valid = 1'b1;
        @(negedge clk_in);
        commit_valid = 1'b0;
    endtask

    // Collect one record. mode 0: ready=1, 1: toggling with 10-cycle hold at
    // word 20, 2: random ready. Optional trace_en drop, stray commits, reset.
    task automatic collect(input int mode, input int drop_at, input bit pulses, input int reset_at);
        bit          started = 0;
        bit          pend = 0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        int          hold = 0;
        int          cyc = 0;
        logic        rdy;
        n_got = 0;
        stall_cyc = 0;
        while (cyc < 600) begin
            commit_valid = 1'b0;
            if (cpu_stall) stall_cyc++;
            checks++;
            if (busy !== cpu_stall || cpu_stall !== out_valid) begin
                errors++;
                $display("FAIL stall_valid_busy busy=%b stall=%b valid=%b required all equal", busy, cpu_stall, out_valid);
            end
            if (out_valid) started = 1;
            if (started && !out_valid) break;
            if (pend) begin
                checks++;
                if (out_data !== pd || out_last !== pl) begin
                    errors++;
                    $display("FAIL hold_stable data=%h last=%b required data=%h last=%b", out_data, out_last, pd, pl);
                end
            end
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    if (n_got == 20 && hold < 10) begin
                        rdy = 1'b0;
                        hold++;
                    end else begin
                        rdy = (cyc % 2 == 0);
                    end
                end
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            out_ready = rdy;
            pend = 0;
            if (out_valid && rdy) begin
                if (n_got < 34) begin
                    checks++;
                    if (dbg_raddr !== ((n_got >= 2) ? 5'(n_got - 2) : 5'd0)) begin
                        errors++;
                        $display("FAIL dbg_raddr word=%0d got=%0d required=%0d", n_got, dbg_raddr,
                                 (n_got >= 2) ? n_got - 2 : 0);
                    end
                end
                if (n_got < 64) begin
                    got_w[n_got] = out_data;
                    got_l[n_got] = out_last;
                end
                n_got++;
            end else if (out_valid) begin
                pend = 1;
                pd = out_data;
                pl = out_last;
            end
            if (drop_at >= 0 && n_got >= drop_at) trace_en = 1'b0;
            if (pulses) begin
                commit_valid = ($urandom_range(0, 1) == 1);
                commit_pc    = $urandom;
                commit_inst  = $urandom;
            end
            if (reset_at >= 0 && n_got == reset_at) begin
                #2 reset = 1'b0;
                #1;
                checks++;
                if (out_valid !== 1'b0 || cpu_stall !== 1'b0 || out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset valid=%b stall=%b last=%b required 0 0 0", out_valid, cpu_stall, out_last);
                end
                @(negedge clk_in);
                reset = 1'b1;
                out_ready = 1'b0;
                commit_valid = 1'b0;
                return;
            end
            @(negedge clk_in);
            cyc++;
        end
        out_ready = 1'b0;
        if (cyc >= 600) begin
            errors++;
            $display("FAIL collect_timeout words=%0d required 35", n_got);
        end
    endtask

    task automatic check_record(input logic [15:0] s, input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] e;
        checks++;
        if (n_got !== 35) begin
            errors++;
            $display("FAIL word_count got=%0d required=35", n_got);
        end
        for (int i = 0; i < 35; i++) begin
            if (i < n_got) begin
                e = exp_word(i, s, pc, inst);
                checks++;
                if (got_w[i] !== e || got_l[i] !== (i == 34)) begin
                    errors++;
                    $display("FAIL record_word%0d got=%h last=%b required=%h last=%b", i, got_w[i], got_l[i], e, (i == 34));
                end
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_in);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0 ||
            cpu_stall !== 1'b0 || busy !== 1'b0 || dbg_raddr !== 5'd0) begin
            errors++;
            $display("FAIL reset_values valid=%b data=%h last=%b stall=%b busy=%b raddr=%0d required all 0",
                     out_valid, out_data, out_last, cpu_stall, busy, dbg_raddr);
        end
        reset = 1'b1;
        @(negedge clk_in);
        checks++;
        if (out_valid !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL after_reset valid=%b stall=%b required 0 0", out_valid, cpu_stall);
        end
        exp_seq = 16'h0000;
    endtask

    task automatic test_single;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'h0000000A;
        trace_en = 1'b1;
        commit(32'h00400000, 32'h2001000A);
        collect(0, -1, 0, -1);
        check_record(exp_seq, 32'h00400000, 32'h2001000A);
        checks++;
        if (stall_cyc !== 35) begin
            errors++;
            $display("FAIL stall_cycles got=%0d required=35", stall_cyc);
        end
        exp_seq++;
    endtask

    task automatic test_backpressure;
        commit(32'h00400000, 32'h2001000A);
        collect(1, -1, 0, -1);
        check_record(exp_seq, 32'h00400000, 32'h2001000A);
        exp_seq++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] pc1, in1, pc2, in2;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        pc1 = $urandom; in1 = $urandom; pc2 = $urandom; in2 = $urandom;
        commit(pc1, in1);
        collect(2, -1, 1, -1);
        check_record(exp_seq, pc1, in1);
        exp_seq++;
        commit(pc2, in2);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart valid=%b required=1", out_valid);
        end
        collect(0, -1, 0, -1);
        check_record(exp_seq, pc2, in2);
        exp_seq++;
        repeat (5) begin
            @(negedge clk_in);
            checks++;
            if (out_valid !== 1'b0 || cpu_stall !== 1'b0) begin
                errors++;
                $display("FAIL no_extra_record valid=%b stall=%b required 0 0", out_valid, cpu_stall);
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] pc, in;
        force dut.seq = 16'hFFFF;
        @(negedge clk_in);
        release dut.seq;
        exp_seq = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            pc = $urandom; in = $urandom;
            commit(pc, in);
            collect(2, -1, 0, -1);
            check_record(exp_seq, pc, in);
            exp_seq++;
        end
    endtask

    task automatic test_trace_en;
        logic [31:0] pc, in;
        trace_en = 1'b0;
        repeat (20) begin
            commit_valid = ($urandom_range(0, 1) == 1);
            commit_pc = $urandom;
            @(negedge clk_in);
            checks++;
            if (out_valid !== 1'b0 || cpu_stall !== 1'b0) begin
                errors++;
                $display("FAIL trace_disabled valid=%b stall=%b required 0 0", out_valid, cpu_stall);
            end
        end
        commit_valid = 1'b0;
        trace_en = 1'b1;
        pc = $urandom; in = $urandom;
        commit(pc, in);
        collect(0, 10, 0, -1);
        check_record(exp_seq, pc, in);
        exp_seq++;
        trace_en = 1'b1;
    endtask

    task automatic test_reset_abort;
        logic [31:0] pc, in;
        pc = $urandom; in = $urandom;
        commit(pc, in);
        collect(0, -1, 0, 17);
        exp_seq = 16'h0000;
        pc = $urandom; in = $urandom;
        commit(pc, in);
        collect(0, -1, 0, -1);
        check_record(exp_seq, pc, in);
        exp_seq++;
    endtask

    task automatic test_raddr;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA0 + i;
        commit(32'h00400010, 32'h00000000);
        collect(2, -1, 0, -1);
        check_record(exp_seq, 32'h00400010, 32'h00000000);
        exp_seq++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_trace_en();
        test_reset_abort();
        test_raddr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
